mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-access stage that sits directly upstream of the word-wide data memory.
//  Accepts load/store requests from the execute stage over a valid/ready handshake.
//  Translates byte and halfword accesses into 32-bit word accesses. Sub-word stores use read-modify-write.
//  Sign- or zero-extends load data and returns one response per request.
// PARAMETERS
//  MEM_WORDS   256  data memory depth in 32-bit words; word index = addr[31:2]
//  BIG_ENDIAN  0    0: byte 0 = bits[7:0]; 1: byte 0 = bits[31:24]
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   unit can accept; high only in IDLE
//  req_we      in   1   1 = store, 0 = load
//  req_size    in   2   00 byte, 01 half, 10 word, 11 reserved (flags error)
//  req_unsigned in  1   loads only: 1 = zero-extend, 0 = sign-extend
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified
//  resp_valid  out  1   response held until resp_ready
//  resp_ready  in   1   consumer accepts response
//  resp_rdata  out  32  extended load data; 0 for stores and errors
//  resp_err    out  1   misaligned / out-of-range / reserved size
//  DAddr       out  32  to data memory: {word index, 2'b00}
//  DataIn      out  32  to data memory: write word
//  WR          out  1   to data memory: write enable, sampled on clk rise
//  DataOut     in   32  from data memory: combinational read of DAddr
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0,
//    resp_err=0, WR=0, DAddr=0, DataIn=0. An in-flight write is aborted immediately.
//    Memory contents are not cleared.
//  - FSM states: IDLE, ACCESS, WRITE, RESP.
//  - IDLE: on req_valid&req_ready, latch we/size/unsigned/addr/wdata.
//    If the request is in error, go to RESP with err=1. Otherwise go to ACCESS.
//  - ACCESS: DAddr = latched word address. Outputs are registered/state-decoded, so WR never glitches.
//    Load: capture and extend the addressed lane of DataOut -> RESP.
//    Word store: WR=1, DataIn=wdata -> RESP.
//    Sub-word store: merge the wdata lane into DataOut, register the result -> WRITE.
//  - WRITE: WR=1, DataIn=merged word, DAddr unchanged -> RESP.
//  - RESP: resp_valid=1 with stable rdata/err. When resp_ready=1, go to IDLE.
//    req_ready returns high the next cycle, so at most one request is outstanding.
//  - Latency from accept edge to resp_valid: load / word store 2 cycles,
//    sub-word store 3 cycles, error 1 cycle.
//  - Lane select uses addr[1:0] (byte) or addr[1] (half), honouring BIG_ENDIAN.
//    Extension replicates bit 7 or bit 15 unless req_unsigned=1.
//  - Error conditions:
//    size=11; word index >= MEM_WORDS; misaligned (half with addr[0]=1, word with addr[1:0]!=0).
//    On error: no memory write, WR stays 0, resp_rdata=0.
//  - Boundary: word index MEM_WORDS-1 is legal. Address bits above the index are
//    checked against MEM_WORDS, never wrapped.
//  - req_valid while busy is ignored (ready=0). Requester must hold its inputs until accepted.
// CONFIGURATION
//  MAU_MISALIGN_CHK_EN defined: misaligned accesses flag resp_err and do not write.
//  MAU_MISALIGN_CHK_EN undefined: low address bits are silently masked to natural alignment.
//    Half: addr[0]=0. Word: addr[1:0]=0. The access then proceeds normally.
//    Only reserved size and out-of-range still set resp_err.
// TESTING
//  1. mem[4]=0x8899AABB; LB addr 0x12 (signed) -> resp after 2 cycles, rdata=0xFFFFFF99, err=0.
//  2. mem[4]=0x8899AABB; SB 0x11 @0x11 -> WR pulses only in WRITE cycle, mem[4]=0x889911BB,
//     resp at 3 cycles.
//  3. LW @0x3FC (index 255) ok; LW @0x400 -> err=1 at 1 cycle, no WR.
//  4. LH @0x13: with MAU_MISALIGN_CHK_EN -> err=1, no access.
//     Without it -> reads halfword @0x12, err=0.
//  5. Hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0.
//     A new req_valid is not accepted until after the handshake.
//  6. Drop rst_n during a sub-word store WRITE -> WR=0 at once, all outputs at reset values,
//     memory word unmodified; next request proceeds normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle between the execute stage and the
// memory-access unit.
//   master : execute stage (drives req_*, resp_ready)
//   slave  : mem_access_unit (drives req_ready, resp_*)
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access stage in front of a word-wide data memory. Converts byte/half/
// word loads and stores into 32-bit word accesses (sub-word stores by
// read-modify-write) and returns one extended response per request.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus (slave) : req valid/ready + we/size/unsigned/addr/wdata,
//                 resp valid/ready + rdata/err
//   DAddr       : word-aligned memory address {index, 2'b00}
//   DataIn, WR  : memory write word and write enable (registered, glitch-free)
//   DataOut     : combinational memory read of DAddr
// Optional: define MAU_MISALIGN_CHK_EN to flag misaligned half/word accesses
// as errors; otherwise the low address bits are masked to natural alignment.
module mem_access_unit #(
  parameter int MEM_WORDS  = 256,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_access_unit_if.slave    bus,
  output logic [31:0]         DAddr,
  output logic [31:0]         DataIn,
  output logic                WR,
  input  logic [31:0]         DataOut
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state_q;
  logic        we_q, uns_q, err_q, wr_q;
  logic [1:0]  size_q, alo_q;
  logic [15:0] wdata_q;
  logic [31:0] rdata_q, daddr_q, din_q;

  // ---- request decode (IDLE) ----
  logic [31:0] eff_addr, idx_ext;
  logic        misalign, oor, req_err;

  always_comb begin
`ifdef MAU_MISALIGN_CHK_EN
    eff_addr = bus.req_addr;
    misalign = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
               (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
    case (bus.req_size)
      2'b01:   eff_addr = {bus.req_addr[31:1], 1'b0};
      2'b10:   eff_addr = {bus.req_addr[31:2], 2'b00};
      default: eff_addr = bus.req_addr;
    endcase
`endif
    // Full-width compare: upper address bits must not alias into memory.
    idx_ext = {2'b00, eff_addr[31:2]};
    oor     = idx_ext >= 32'(MEM_WORDS);
    req_err = (bus.req_size == 2'b11) || oor || misalign;
  end

  // ---- lane select / extend / merge (ACCESS) ----
  logic [4:0]  sh;
  logic [31:0] lane, ld_ext, lmask, merged;

  always_comb begin
    case (size_q)
      2'b00:   sh = BIG_ENDIAN ? {~alo_q, 3'b000} : {alo_q, 3'b000};
      2'b01:   sh = BIG_ENDIAN ? {~alo_q[1], 4'b0000} : {alo_q[1], 4'b0000};
      default: sh = 5'd0;
    endcase
    lane = DataOut >> sh;
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b01:   ld_ext = uns_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ld_ext = lane;
    endcase
    lmask  = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merged = (DataOut & ~lmask) | (({16'd0, wdata_q} << sh) & lmask);
  end

  // ---- FSM with registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      alo_q   <= 2'b00;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      daddr_q <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_q <= 1'b0;
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            alo_q   <= eff_addr[1:0];
            wdata_q <= bus.req_wdata[15:0];
            rdata_q <= '0;
            err_q   <= req_err;
            if (req_err) begin
              state_q <= RESP;
            end else begin
              daddr_q <= {eff_addr[31:2], 2'b00};
              state_q <= ACCESS;
              // Word stores write straight from ACCESS; raise WR with the state.
              if (bus.req_we && bus.req_size == 2'b10) begin
                wr_q  <= 1'b1;
                din_q <= bus.req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= ld_ext;
            state_q <= RESP;
          end else if (size_q == 2'b10) begin
            wr_q    <= 1'b0;
            state_q <= RESP;
          end else begin
            din_q   <= merged;
            wr_q    <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          wr_q    <= 1'b0;
          state_q <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign DAddr          = daddr_q;
  assign DataIn         = din_q;
  assign WR             = wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  logic        clk, rst_n;
  logic [31:0] DAddr, DataIn, DataOut;
  logic        WR;
  logic [31:0] mem [256];
  int          n_pass, n_total;

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_WORDS(256), .BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .DAddr(DAddr), .DataIn(DataIn), .WR(WR), .DataOut(DataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: combinational read, write on rising edge.
  assign DataOut = mem[DAddr[9:2]];
  always @(posedge clk) if (WR) mem[DAddr[9:2]] <= DataIn;

  // Issue one request, count edges until resp_valid (bounded), then handshake.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata,
                        output logic err, output int wrc);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; wrc = 0;
    while (!bus.resp_valid && lat < 20) begin
      if (WR) wrc++;
      @(posedge clk); #1;
      lat++;
    end
    rdata = bus.resp_rdata; err = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    n_total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.req_ready); else n_pass++;
    n_total++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid); else n_pass++;
    n_total++; if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0)
      $display("FAIL reset_resp got %h/%b want 0/0", bus.resp_rdata, bus.resp_err); else n_pass++;
    n_total++; if (WR !== 1'b0 || DAddr !== 32'h0 || DataIn !== 32'h0)
      $display("FAIL reset_mem_if got WR=%b DAddr=%h DataIn=%h want 0/0/0", WR, DAddr, DataIn); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_loads;
    int lat, wrc; logic [31:0] rd; logic er;
    mem[4] = 32'h8899AABB;
    do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, lat, rd, er, wrc);
    n_total++; if (lat != 2 || rd !== 32'hFFFFFF99 || er !== 1'b0 || wrc != 0)
      $display("FAIL lb_signed got lat=%0d rd=%h err=%b wr=%0d want 2/ffffff99/0/0", lat, rd, er, wrc); else n_pass++;
    do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, lat, rd, er, wrc);
    n_total++; if (rd !== 32'h000000BB || er !== 1'b0)
      $display("FAIL lbu got rd=%h err=%b want 000000bb/0", rd, er); else n_pass++;
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, rd, er, wrc);
    n_total++; if (rd !== 32'hFFFFAABB || lat != 2)
      $display("FAIL lh_signed got rd=%h lat=%0d want ffffaabb/2", rd, lat); else n_pass++;
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, er, wrc);
    n_total++; if (rd !== 32'h00008899)
      $display("FAIL lhu got rd=%h want 00008899", rd); else n_pass++;
  endtask

  task automatic test_subword_store;
    int lat, wrc; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000011, lat, rd, er, wrc);
    n_total++; if (lat != 3 || wrc != 1 || rd !== 32'h0 || er !== 1'b0)
      $display("FAIL sb_timing got lat=%0d wr=%0d rd=%h err=%b want 3/1/0/0", lat, wrc, rd, er); else n_pass++;
    n_total++; if (mem[4] !== 32'h889911BB)
      $display("FAIL sb_merge got %h want 889911bb", mem[4]); else n_pass++;
    mem[8] = 32'h11223344;
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h5555CAFE, lat, rd, er, wrc);
    n_total++; if (mem[8] !== 32'hCAFE3344 || lat != 3)
      $display("FAIL sh_merge got %h lat=%0d want cafe3344/3", mem[8], lat); else n_pass++;
  endtask

  task automatic test_word_and_range;
    int lat, wrc; logic [31:0] rd; logic er;
    do_req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hDEADBEEF, lat, rd, er, wrc);
    n_total++; if (lat != 2 || wrc != 1 || mem[255] !== 32'hDEADBEEF)
      $display("FAIL sw_last got lat=%0d wr=%0d mem=%h want 2/1/deadbeef", lat, wrc, mem[255]); else n_pass++;
    do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, lat, rd, er, wrc);
    n_total++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 2)
      $display("FAIL lw_last got rd=%h err=%b lat=%0d want deadbeef/0/2", rd, er, lat); else n_pass++;
    do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, lat, rd, er, wrc);
    n_total++; if (er !== 1'b1 || lat != 1 || wrc != 0 || rd !== 32'h0)
      $display("FAIL lw_oor got err=%b lat=%0d wr=%0d rd=%h want 1/1/0/0", er, lat, wrc, rd); else n_pass++;
    mem[4] = 32'h0BADF00D;
    do_req(1'b1, 2'b10, 1'b0, 32'h80000010, 32'h12345678, lat, rd, er, wrc);
    n_total++; if (er !== 1'b1 || wrc != 0 || mem[4] !== 32'h0BADF00D)
      $display("FAIL sw_high_bits got err=%b wr=%0d mem=%h want 1/0/0badf00d", er, wrc, mem[4]); else n_pass++;
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, er, wrc);
    n_total++; if (er !== 1'b1 || lat != 1 || rd !== 32'h0)
      $display("FAIL reserved_size got err=%b lat=%0d rd=%h want 1/1/0", er, lat, rd); else n_pass++;
  endtask

  task automatic test_misalign;
    int lat, wrc; logic [31:0] rd; logic er;
    mem[5] = 32'h8899AABB;
    do_req(1'b0, 2'b01, 1'b0, 32'h17, 32'h0, lat, rd, er, wrc);
`ifdef MAU_MISALIGN_CHK_EN
    n_total++; if (er !== 1'b1 || lat != 1 || rd !== 32'h0)
      $display("FAIL lh_misalign got err=%b lat=%0d rd=%h want 1/1/0", er, lat, rd); else n_pass++;
`else
    n_total++; if (er !== 1'b0 || lat != 2 || rd !== 32'hFFFF8899)
      $display("FAIL lh_masked got err=%b lat=%0d rd=%h want 0/2/ffff8899", er, lat, rd); else n_pass++;
`endif
    do_req(1'b1, 2'b10, 1'b0, 32'h16, 32'h12345678, lat, rd, er, wrc);
`ifdef MAU_MISALIGN_CHK_EN
    n_total++; if (er !== 1'b1 || wrc != 0 || mem[5] !== 32'h8899AABB)
      $display("FAIL sw_misalign got err=%b wr=%0d mem=%h want 1/0/8899aabb", er, wrc, mem[5]); else n_pass++;
`else
    n_total++; if (er !== 1'b0 || wrc != 1 || mem[5] !== 32'h12345678)
      $display("FAIL sw_masked got err=%b wr=%0d mem=%h want 0/1/12345678", er, wrc, mem[5]); else n_pass++;
`endif
  endtask

  task automatic test_backpressure;
    int lat, wrc, bad; logic [31:0] rd, rd0; logic er;
    mem[4] = 32'hA5A5_0001; mem[7] = 32'h0000_7777;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    // Second request presented while the first is still in flight.
    bus.req_addr = 32'h1C;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_total++; if (lat != 2) $display("FAIL bp_latency got %0d want 2", lat); else n_pass++;
    rd0 = bus.resp_rdata; bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rd0 || bus.req_ready !== 1'b0) bad++;
    end
    n_total++; if (rd0 !== 32'hA5A50001) $display("FAIL bp_rdata got %h want a5a50001", rd0); else n_pass++;
    n_total++; if (bad != 0) $display("FAIL bp_hold got %0d unstable cycles want 0", bad); else n_pass++;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    n_total++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0)
      $display("FAIL bp_release got ready=%b valid=%b want 1/0", bus.req_ready, bus.resp_valid); else n_pass++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = bus.resp_rdata;
    n_total++; if (rd !== 32'h00007777 || lat != 2)
      $display("FAIL bp_second got rd=%h lat=%0d want 00007777/2", rd, lat); else n_pass++;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    er = 1'b0; wrc = 0;
  endtask

  task automatic test_reset_mid_write;
    int lat, wrc; logic [31:0] rd; logic er;
    mem[6] = 32'h01020304;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h18; bus.req_wdata = 32'hFF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    n_total++; if (WR !== 1'b1) $display("FAIL rst_write_entered got WR=%b want 1", WR); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (WR !== 1'b0 || DAddr !== 32'h0 || DataIn !== 32'h0 || bus.resp_valid !== 1'b0 ||
                   bus.req_ready !== 1'b1 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0)
      $display("FAIL rst_abort got WR=%b DAddr=%h DataIn=%h rv=%b rr=%b want 0/0/0/0/1",
               WR, DAddr, DataIn, bus.resp_valid, bus.req_ready); else n_pass++;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    n_total++; if (mem[6] !== 32'h01020304)
      $display("FAIL rst_mem_intact got %h want 01020304", mem[6]); else n_pass++;
    do_req(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, lat, rd, er, wrc);
    n_total++; if (rd !== 32'h01020304 || lat != 2 || er !== 1'b0)
      $display("FAIL rst_recover got rd=%h lat=%0d err=%b want 01020304/2/0", rd, lat, er); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset;
    test_loads;
    test_subword_store;
    test_word_and_range;
    test_misalign;
    test_backpressure;
    test_reset_mid_write;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
